// File: rtl/flit_sink_monitor.sv
// flit_sink_monitor: receive-side monitor for the {type, payload} flit stream.
// Tracks head/data/tail framing, counts packets and flits, accumulates payload
// toggle activity and records protocol violations in sticky error bits.
// Optional feature: define FLIT_SINK_TOGGLE_EN to build the toggle counter;
// otherwise toggle_cnt is tied to 0.
// Ports:
//   clk, rst_          clock, async active-low reset
//   idata/ivalid/ivch  flit {type, payload}, valid, virtual channel
//   clr                sync clear of counters, err and last_len
//   busy               1 while a packet is open
//   pkt_cnt, flit_cnt, toggle_cnt, last_len, cur_vch, err  statistics
module flit_sink_monitor #(
  parameter int unsigned DATAW = 64,
  parameter int unsigned TYPEW = 2,
  parameter int unsigned VCHW  = 2,
  parameter int unsigned CNTW  = 32,
  parameter int unsigned LENW  = 16
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [TYPEW+DATAW-1:0] idata,
  input  logic                   ivalid,
  input  logic [VCHW-1:0]        ivch,
  input  logic                   clr,
  output logic                   busy,
  output logic [CNTW-1:0]        pkt_cnt,
  output logic [CNTW-1:0]        flit_cnt,
  output logic [CNTW-1:0]        toggle_cnt,
  output logic [LENW-1:0]        last_len,
  output logic [VCHW-1:0]        cur_vch,
  output logic [3:0]             err
);

  localparam logic [TYPEW-1:0] T_NONE = TYPEW'(0);
  localparam logic [TYPEW-1:0] T_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] T_TAIL = TYPEW'(2);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  logic [0:0]       r_state;
  logic [LENW-1:0]  r_len;

  logic [TYPEW-1:0] w_type;
  logic [0:0]       w_state_nxt;
  logic [LENW-1:0]  w_len_nxt;
  logic [LENW-1:0]  w_len_inc;
  logic [VCHW-1:0]  w_vch_nxt;
  logic [3:0]       w_err_set;
  logic             w_pkt_done;

  assign w_type    = idata[TYPEW+DATAW-1:DATAW];
  assign w_len_inc = (r_len == '1) ? r_len : r_len + LENW'(1);

  // Framing decode: next state, length, vch and error events for this flit
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_vch_nxt   = cur_vch;
    w_err_set   = 4'b0000;
    w_pkt_done  = 1'b0;
    if (ivalid) begin
      case (w_type)
        T_NONE: w_err_set[3] = 1'b1;
        T_HEAD: begin
          // A head inside an open packet abandons it and starts a new one
          if (r_state == S_BODY) w_err_set[1] = 1'b1;
          w_state_nxt = S_BODY;
          w_len_nxt   = LENW'(1);
          w_vch_nxt   = ivch;
        end
        default: begin
          if (r_state == S_IDLE) begin
            w_err_set[0] = 1'b1;
          end else begin
            if (ivch != cur_vch) w_err_set[2] = 1'b1;
            w_len_nxt = w_len_inc;
            if (w_type == T_TAIL) begin
              w_pkt_done  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      endcase
    end
  end

  // FSM state and per-packet context; unaffected by clr
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      cur_vch <= '0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      cur_vch <= w_vch_nxt;
      busy    <= (w_state_nxt == S_BODY);
    end
  end

  // Saturating statistics and sticky errors; clr wins over a same-cycle flit
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      last_len <= '0;
      err      <= 4'b0000;
    end else if (clr) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
      last_len <= '0;
      err      <= 4'b0000;
    end else begin
      if (ivalid && (flit_cnt != '1)) flit_cnt <= flit_cnt + CNTW'(1);
      if (w_pkt_done) begin
        last_len <= w_len_nxt;
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNTW'(1);
      end
      err <= err | w_err_set;
    end
  end

`ifdef FLIT_SINK_TOGGLE_EN
  localparam int unsigned PCW  = $clog2(DATAW) + 1;
  localparam int unsigned SUMW = CNTW + 1;

  logic [DATAW-1:0] r_prev;
  logic [DATAW-1:0] w_diff;
  logic [PCW-1:0]   w_pop;
  logic [SUMW-1:0]  w_tog_sum;

  assign w_diff    = idata[DATAW-1:0] ^ r_prev;
  assign w_tog_sum = {1'b0, toggle_cnt} + SUMW'(w_pop);

  // Hamming distance between this payload and the previous valid payload
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DATAW; i++) w_pop = w_pop + PCW'(w_diff[i]);
  end

  // prev follows every valid flit, even when clr zeroes the count
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_prev     <= '0;
      toggle_cnt <= '0;
    end else begin
      if (ivalid) r_prev <= idata[DATAW-1:0];
      if (clr) begin
        toggle_cnt <= '0;
      end else if (ivalid) begin
        toggle_cnt <= w_tog_sum[CNTW] ? '1 : w_tog_sum[CNTW-1:0];
      end
    end
  end
`else
  logic w_unused_payload;
  assign w_unused_payload = ^idata[DATAW-1:0];
  assign toggle_cnt       = '0;
`endif

endmodule

// File: tb/tb_flit_sink_monitor.sv
// tb_flit_sink_monitor: directed self-checking bench for flit_sink_monitor.
// Drives flits on the falling edge, samples outputs 1 time unit after the
// rising edge. Follows FLIT_SINK_TOGGLE_EN for toggle expectations.
module tb_flit_sink_monitor;

  localparam int unsigned DATAW = 64;
  localparam int unsigned TYPEW = 2;
  localparam int unsigned VCHW  = 2;
  localparam int unsigned CNTW  = 32;
  localparam int unsigned LENW  = 16;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] TAIL = 2'b10;
  localparam logic [1:0] DATA = 2'b11;

  logic                   clk = 1'b0;
  logic                   rst_ = 1'b0;
  logic [TYPEW+DATAW-1:0] idata = '0;
  logic                   ivalid = 1'b0;
  logic [VCHW-1:0]        ivch = '0;
  logic                   clr = 1'b0;
  logic                   busy;
  logic [CNTW-1:0]        pkt_cnt, flit_cnt, toggle_cnt;
  logic [LENW-1:0]        last_len;
  logic [VCHW-1:0]        cur_vch;
  logic [3:0]             err;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] prev_m = '0;
  logic [63:0] tog_m  = '0;

  flit_sink_monitor #(
    .DATAW(DATAW), .TYPEW(TYPEW), .VCHW(VCHW), .CNTW(CNTW), .LENW(LENW)
  ) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .clr(clr), .busy(busy), .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt),
    .toggle_cnt(toggle_cnt), .last_len(last_len), .cur_vch(cur_vch), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One valid flit; updates the toggle model alongside
  task automatic send(input logic [1:0] t, input logic [1:0] v, input logic [63:0] p);
    @(negedge clk);
    idata  = {t, p};
    ivch   = v;
    ivalid = 1'b1;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    if (clr) tog_m = '0;
`ifdef FLIT_SINK_TOGGLE_EN
    else tog_m = tog_m + 64'($countones(p ^ prev_m));
`endif
    prev_m = p;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    tog_m = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pkt"}, 64'(pkt_cnt), 64'd0);
    chk({tag, "_flit"}, 64'(flit_cnt), 64'd0);
    chk({tag, "_tog"}, 64'(toggle_cnt), 64'd0);
    chk({tag, "_len"}, 64'(last_len), 64'd0);
    chk({tag, "_vch"}, 64'(cur_vch), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic [63:0] ones;
    ones = '1;

    // Reset state
    #12;
    chk_zero("rst");
    @(negedge clk);
    rst_ = 1'b1;

    // HEAD, 20 DATA, TAIL on vch 1, back-to-back
    send(HEAD, 2'd1, 64'h0123_4567_89AB_CDEF);
    chk("t1_busy_head", 64'(busy), 64'd1);
    for (int i = 0; i < 20; i++)
      send(DATA, 2'd1, {32'(i) * 32'h0101_0101, 32'hFFFF_0000 ^ 32'(i)});
    send(TAIL, 2'd1, 64'd0);
    chk("t1_pkt", 64'(pkt_cnt), 64'd1);
    chk("t1_flit", 64'(flit_cnt), 64'd22);
    chk("t1_len", 64'(last_len), 64'd22);
    chk("t1_vch", 64'(cur_vch), 64'd1);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_tog", 64'(toggle_cnt), tog_m);

    // Payloads 0, all-ones, 0
    do_clr();
    send(HEAD, 2'd0, 64'd0);
    send(DATA, 2'd0, ones);
    send(TAIL, 2'd0, 64'd0);
`ifdef FLIT_SINK_TOGGLE_EN
    chk("t2_tog", 64'(toggle_cnt), 64'd128);
`else
    chk("t2_tog", 64'(toggle_cnt), 64'd0);
`endif
    chk("t2_pkt", 64'(pkt_cnt), 64'd1);
    chk("t2_len", 64'(last_len), 64'd3);

    // TAIL without HEAD
    do_clr();
    send(TAIL, 2'd0, 64'h55);
    chk("t3_err", 64'(err), 64'b0001);
    chk("t3_pkt", 64'(pkt_cnt), 64'd0);
    chk("t3_flit", 64'(flit_cnt), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);

    // HEAD inside an open packet; repeated identical DATA flits
    do_clr();
    send(HEAD, 2'd0, 64'hF0);
    for (int i = 0; i < 3; i++) send(DATA, 2'd0, 64'hDEAD_BEEF);
    chk("t4_tog_hold", 64'(toggle_cnt), tog_m);
    send(HEAD, 2'd0, 64'h1);
    send(DATA, 2'd0, 64'h3);
    send(DATA, 2'd0, 64'h7);
    send(TAIL, 2'd0, 64'hF);
    chk("t4_err", 64'(err), 64'b0010);
    chk("t4_pkt", 64'(pkt_cnt), 64'd1);
    chk("t4_len", 64'(last_len), 64'd4);
    chk("t4_flit", 64'(flit_cnt), 64'd8);
    chk("t4_tog", 64'(toggle_cnt), tog_m);

    // vch change mid-packet, then clr
    do_clr();
    send(HEAD, 2'd0, 64'd0);
    send(DATA, 2'd2, 64'hAA);
    send(TAIL, 2'd0, 64'hAB);
    chk("t5_err", 64'(err), 64'b0100);
    chk("t5_pkt", 64'(pkt_cnt), 64'd1);
    chk("t5_len", 64'(last_len), 64'd3);
    do_clr();
    chk_zero("t5_clr");

    // Valid NONE inside a packet
    send(HEAD, 2'd3, 64'h1);
    send(NONE, 2'd3, 64'h2);
    chk("t6_err", 64'(err), 64'b1000);
    chk("t6_busy", 64'(busy), 64'd1);
    chk("t6_flit", 64'(flit_cnt), 64'd2);
    send(TAIL, 2'd3, 64'h3);
    chk("t6_len", 64'(last_len), 64'd2);
    chk("t6_pkt", 64'(pkt_cnt), 64'd1);
    chk("t6_vch", 64'(cur_vch), 64'd3);
    chk("t6_tog", 64'(toggle_cnt), tog_m);

    // clr coinciding with a HEAD
    clr = 1'b1;
    send(HEAD, 2'd1, 64'hFF);
    clr = 1'b0;
    chk("t7_flit", 64'(flit_cnt), 64'd0);
    chk("t7_err", 64'(err), 64'd0);
    chk("t7_busy", 64'(busy), 64'd1);
    chk("t7_vch", 64'(cur_vch), 64'd1);
    chk("t7_tog", 64'(toggle_cnt), 64'd0);
    send(TAIL, 2'd1, 64'h0);
    chk("t7_pkt", 64'(pkt_cnt), 64'd1);
    chk("t7_len", 64'(last_len), 64'd2);
    chk("t7_flit2", 64'(flit_cnt), 64'd1);
    chk("t7_tog2", 64'(toggle_cnt), tog_m);

    // Reset mid-packet
    send(HEAD, 2'd2, 64'h10);
    for (int i = 0; i < 5; i++) send(DATA, 2'd2, 64'(i) << 8);
    #2;
    rst_ = 1'b0;
    #1;
    chk_zero("t8_rst");
    prev_m = '0;
    tog_m  = '0;
    @(negedge clk);
    rst_ = 1'b1;
    send(DATA, 2'd2, 64'h5);
    send(TAIL, 2'd2, 64'h6);
    chk("t8_err", 64'(err), 64'b0001);
    chk("t8_pkt", 64'(pkt_cnt), 64'd0);
    chk("t8_busy", 64'(busy), 64'd0);
    chk("t8_flit", 64'(flit_cnt), 64'd2);
    chk("t8_tog", 64'(toggle_cnt), tog_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flit_sink_monitor.md
# flit_sink_monitor

- Receive end of the router flit interface: sinks the `{type, payload}` flit stream driven out of a mux or router output port.
- Tracks packet framing (head/data/tail) with a small state machine.
- Counts packets and flits, measures payload bit-toggle activity for energy characterization runs, and flags protocol violations in sticky error bits.
- Sits directly on a mux output (`odata`/`ovalid`/`ovch`) in characterization benches and as a synthesizable port monitor.

## Interface
- `DATAW`, 64, payload width in bits.
- `TYPEW`, 2, flit type field width; the flit is `{type, payload}`, `TYPEW+DATAW` bits wide.
- `VCHW`, 2, virtual-channel id width.
- `CNTW`, 32, width of the packet, flit and toggle counters.
- `LENW`, 16, width of the packet-length register.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_`  input  1  reset, asynchronous, active-low.
- `idata`  input  TYPEW+DATAW  flit; type in the MSBs: NONE=2'b00, HEAD=2'b01, TAIL=2'b10, DATA=2'b11.
- `ivalid`  input  1  flit valid; the flit is sampled on any edge where this is 1.
- `ivch`  input  VCHW  virtual channel of the flit.
- `clr`  input  1  synchronous clear of counters, errors and last_len; the FSM is not cleared.
- `busy`  output  1  1 while in BODY state.
- `pkt_cnt`  output  CNTW  completed packets.
- `flit_cnt`  output  CNTW  accepted valid flits of any type.
- `toggle_cnt`  output  CNTW  cumulative payload Hamming distance between consecutive valid flits.
- `last_len`  output  LENW  flit count of the last completed packet, head and tail included.
- `cur_vch`  output  VCHW  vch latched at the head of the current or last packet.
- `err`  output  4  sticky error bits: [0] DATA/TAIL in IDLE, [1] HEAD in BODY, [2] vch change mid-packet, [3] valid with type NONE.

## Operation
- **Reset.** All outputs are 0, the FSM is in IDLE, and the previous-payload register is 0.
- **IDLE state:**
  - Valid HEAD moves to BODY, latches `ivch` into `cur_vch` and sets len=1.
  - Valid DATA or TAIL sets err[0]; the flit is dropped and the state stays IDLE.
- **BODY state:**
  - DATA: len+1.
  - TAIL: len+1, `last_len`←len+1, pkt_cnt+1, go to IDLE.
  - HEAD: sets err[1]; the open packet is abandoned with no pkt_cnt change; a new packet starts with len=1 and `cur_vch` re-latched.
  - Any DATA/TAIL whose `ivch` ≠ `cur_vch` sets err[2]; the flit is still processed normally.
- **Type NONE with `ivalid`=1:**
  - sets err[3];
  - no state, len or pkt_cnt change;
  - still counted in flit_cnt and toggle.
- **flit_cnt** increments on every valid flit, including erroneous ones.
- **Toggle:** on every valid flit, toggle_cnt += popcount(payload ^ prev), then prev←payload.
  - The type field is excluded.
  - popcount is `$clog2(DATAW)+1` bits wide.
- **Saturation:** all counters saturate at all-ones and do not wrap; len saturates at 2^LENW−1.
- **clr:**
  - Zeroes pkt_cnt, flit_cnt, toggle_cnt, last_len and err.
  - If `clr` coincides with a valid flit, `clr` wins for counters and err; the FSM, len, `cur_vch` and prev still update from the flit.
- **Reset mid-packet:** returns to IDLE immediately; a following DATA raises err[0].

## Timing
- Every output is registered; the effect of a flit sampled at edge N is visible after edge N, so latency is 1 cycle.
- No backpressure: the sink accepts one flit per cycle unconditionally.
- Back-to-back packets (TAIL at N, HEAD at N+1) are legal and error-free.
- Holding `ivalid`=1 with an unchanged flit counts it again every cycle and adds 0 toggles.
- Asserting `rst_` low forces outputs to 0 asynchronously; release is synchronized externally.

## Configuration
- `FLIT_SINK_TOGGLE_EN` defined:
  - the popcount logic and prev register are built;
  - toggle_cnt operates as specified.
- Not defined:
  - the popcount logic and prev register are removed;
  - toggle_cnt is tied to 0;
  - all other behaviour is identical.

## Test plan
- HEAD, 20 DATA, TAIL on vch 1, back-to-back → pkt_cnt=1, flit_cnt=22, last_len=22, cur_vch=1, err=0, busy=0 one cycle after TAIL.
- Payloads 0, all-ones, 0 on three valid flits (TOGGLE_EN defined) → toggle_cnt=128; same run with the macro undefined → toggle_cnt=0.
- TAIL with no preceding HEAD → err=4'b0001, pkt_cnt=0, flit_cnt=1, busy=0.
- HEAD, 3 DATA, HEAD, 2 DATA, TAIL → err[1]=1, pkt_cnt=1, last_len=4.
- HEAD on vch 0, DATA on vch 2, TAIL → err=4'b0100, pkt_cnt=1; then `clr` → all counters, err and last_len are 0.
- `rst_` pulsed low after HEAD+5 DATA, then DATA, TAIL → all outputs 0 during reset, err=4'b0001 afterwards, pkt_cnt=0.
